// File: rtl/puzzle_runner_if.sv
// puzzle_runner_if: host-side and puzzle-side signals of one puzzle run controller.
// master: host/sequencer side (drives go, sees results) plus puzzle outputs stopped/colour.
// slave: the run controller itself.
interface puzzle_runner_if #(
  parameter int LOG_DEPTH = 8,
  parameter int CW        = 16
);
  localparam int LCW = $clog2(LOG_DEPTH + 1);

  logic                 go;
  logic                 busy;
  logic                 done;
  logic                 start;
  logic                 stopped;
  logic                 colour;
  logic                 result_colour;
  logic                 result_timeout;
  logic [CW-1:0]        run_cycles;
  logic [LOG_DEPTH-1:0] colour_log;
  logic [LCW-1:0]       log_count;

  modport master (
    output go, stopped, colour,
    input  busy, done, start, result_colour, result_timeout,
           run_cycles, colour_log, log_count
  );

  modport slave (
    input  go, stopped, colour,
    output busy, done, start, result_colour, result_timeout,
           run_cycles, colour_log, log_count
  );
endinterface

// File: rtl/puzzle_runner.sv
// puzzle_runner: pulses puzzle start, masks stopped while settling, waits for stop/timeout, reports result.
// Latency: go at edge k -> start/busy from edge k; done earliest START_W+SETTLE+1 cycles later.
// Backpressure: none; go is sampled only in IDLE and is otherwise dropped, not queued.
// Ports: clk, rst (sync, active-high); bus.go/busy/done to host; bus.start/stopped/colour to puzzle;
//        bus.result_colour/result_timeout/run_cycles/colour_log/log_count hold until the next run starts.
module puzzle_runner #(
  parameter int START_W   = 2,
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 255,
  parameter int LOG_DEPTH = 8,
  parameter int CW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  puzzle_runner_if.slave  bus
);

  localparam int LCW   = $clog2(LOG_DEPTH + 1);
  localparam int PMAX0 = (START_W > SETTLE) ? START_W : SETTLE;
  localparam int PMAX  = (PMAX0 > TIMEOUT) ? PMAX0 : TIMEOUT;
  localparam int PW    = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic                 res_col_q, res_col_d;
  logic                 res_to_q, res_to_d;
  logic [CW-1:0]        run_q, run_d;
  logic [LOG_DEPTH-1:0] log_q, log_d;
  logic [LCW-1:0]       lcnt_q, lcnt_d;

  // Two-flop synchronisers for the asynchronous puzzle outputs; col_prev_q
  // holds last cycle's synchronised colour for transition detection.
  logic stp_s1_q, stp_s2_q;
  logic col_s1_q, col_s2_q;
  logic col_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_col_d = res_col_q;
    res_to_d  = res_to_q;
    run_d     = run_q;
    log_d     = log_q;
    lcnt_d    = lcnt_q;

    // Run length and colour log only advance while the ball chain is live.
    if (state_q == ST_SETTLE || state_q == ST_WAIT) begin
      if (run_q != {CW{1'b1}}) begin
        run_d = run_q + 1'b1;
      end
      if (col_s2_q != col_prev_q) begin
        log_d = (log_q << 1) | LOG_DEPTH'(col_s2_q);
        if (lcnt_q != LCW'(LOG_DEPTH)) begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          state_d  = ST_START;
          cnt_d    = PW'(START_W);
          run_d    = '0;
          log_d    = '0;
          lcnt_d   = '0;
          res_to_d = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == PW'(1)) begin
          if (SETTLE == 0) begin
            state_d = ST_WAIT;
            cnt_d   = PW'(TIMEOUT);
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = PW'(SETTLE);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == PW'(1)) begin
          state_d = ST_WAIT;
          cnt_d   = PW'(TIMEOUT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        // Stop is tested first so it wins over a coincident timeout.
        if (stp_s2_q) begin
          state_d   = ST_DONE;
          res_col_d = col_s2_q;
          res_to_d  = 1'b0;
        end else if (cnt_q == PW'(1)) begin
          state_d   = ST_DONE;
          res_col_d = col_s2_q;
          res_to_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      res_col_q  <= 1'b0;
      res_to_q   <= 1'b0;
      run_q      <= '0;
      log_q      <= '0;
      lcnt_q     <= '0;
      stp_s1_q   <= 1'b0;
      stp_s2_q   <= 1'b0;
      col_s1_q   <= 1'b0;
      col_s2_q   <= 1'b0;
      col_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_col_q  <= res_col_d;
      res_to_q   <= res_to_d;
      run_q      <= run_d;
      log_q      <= log_d;
      lcnt_q     <= lcnt_d;
      stp_s1_q   <= bus.stopped;
      stp_s2_q   <= stp_s1_q;
      col_s1_q   <= bus.colour;
      col_s2_q   <= col_s1_q;
      col_prev_q <= col_s2_q;
    end
  end

  // Control outputs are pure decodes of the state register.
  assign bus.start          = (state_q == ST_START);
  assign bus.busy           = (state_q == ST_START) || (state_q == ST_SETTLE) || (state_q == ST_WAIT);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.result_colour  = res_col_q;
  assign bus.result_timeout = res_to_q;
  assign bus.run_cycles     = run_q;
  assign bus.colour_log     = log_q;
  assign bus.log_count      = lcnt_q;

endmodule

// File: tb/tb_puzzle_runner.sv
module tb_puzzle_runner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  puzzle_runner_if #(.LOG_DEPTH(8), .CW(16)) b1 ();
  puzzle_runner_if #(.LOG_DEPTH(8), .CW(4))  b2 ();

  puzzle_runner #(.START_W(2), .SETTLE(4), .TIMEOUT(255), .LOG_DEPTH(8), .CW(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  puzzle_runner #(.START_W(2), .SETTLE(4), .TIMEOUT(20), .LOG_DEPTH(8), .CW(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  typedef struct {
    int   cyc;
    logic col;
    logic to;
    int   rc;
    int   lg;
    int   cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic col, input logic to,
                       input logic [31:0] rc, input logic [31:0] lg, input logic [31:0] cnt,
                       input logic busy);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_result_colour"}, {31'd0, col}, {31'd0, e.col});
    chk({tag, "_result_timeout"}, {31'd0, to}, {31'd0, e.to});
    chk({tag, "_run_cycles"}, rc, e.rc);
    chk({tag, "_colour_log"}, lg, e.lg);
    chk({tag, "_log_count"}, cnt, e.cnt);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitors: every done pulse consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (b1.done === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_unexpected_done: got done=1 at cycle %0d, want no pending result", cyc);
      end else begin
        e = q1.pop_front();
        score("dut1", e, b1.result_colour, b1.result_timeout, 32'(b1.run_cycles),
              32'(b1.colour_log), 32'(b1.log_count), b1.busy);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b2.done === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut2_unexpected_done: got done=1 at cycle %0d, want no pending result", cyc);
      end else begin
        e = q2.pop_front();
        score("dut2", e, b2.result_colour, b2.result_timeout, 32'(b2.run_cycles),
              32'(b2.colour_log), 32'(b2.log_count), b2.busy);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse go for one edge; returns the edge number at which START begins.
  task automatic go1(output int g);
    @(negedge clk);
    b1.go = 1'b1;
    g = cyc + 1;
    @(negedge clk);
    b1.go = 1'b0;
  endtask

  task automatic go2(output int g);
    @(negedge clk);
    b2.go = 1'b1;
    g = cyc + 1;
    @(negedge clk);
    b2.go = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_start"}, {31'd0, b1.start}, 32'd0);
    chk({tag, "_busy"}, {31'd0, b1.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, b1.done}, 32'd0);
    chk({tag, "_result_colour"}, {31'd0, b1.result_colour}, 32'd0);
    chk({tag, "_result_timeout"}, {31'd0, b1.result_timeout}, 32'd0);
    chk({tag, "_run_cycles"}, 32'(b1.run_cycles), 32'd0);
    chk({tag, "_colour_log"}, 32'(b1.colour_log), 32'd0);
    chk({tag, "_log_count"}, 32'(b1.log_count), 32'd0);
  endtask

  initial begin
    int g;
    b1.go = 1'b0; b1.stopped = 1'b0; b1.colour = 1'b0;
    b2.go = 1'b0; b2.stopped = 1'b0; b2.colour = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    // Stopped already high: masked until the first WAIT cycle.
    b1.stopped = 1'b1;
    b1.colour  = 1'b1;
    repeat (4) @(negedge clk);
    go1(g);
    q1.push_back('{g + 7, 1'b1, 1'b0, 5, 0, 0});
    chk("t1_start_c1", {31'd0, b1.start}, 32'd1);
    chk("t1_busy_c1", {31'd0, b1.busy}, 32'd1);
    @(negedge clk);
    chk("t1_start_c2", {31'd0, b1.start}, 32'd1);
    @(negedge clk);
    chk("t1_start_c3", {31'd0, b1.start}, 32'd0);
    chk("t1_busy_c3", {31'd0, b1.busy}, 32'd1);
    wait_until(g + 12);

    // Stopped held low: timeout after 255 WAIT cycles.
    b1.stopped = 1'b0;
    b1.colour  = 1'b0;
    repeat (4) @(negedge clk);
    go1(g);
    q1.push_back('{g + 261, 1'b0, 1'b1, 259, 0, 0});
    wait_until(g + 266);

    // Stop seen in the very last WAIT cycle beats the timeout.
    b1.colour = 1'b1;
    repeat (4) @(negedge clk);
    go1(g);
    q1.push_back('{g + 261, 1'b1, 1'b0, 259, 0, 0});
    wait_until(g + 258);
    b1.stopped = 1'b1;
    wait_until(g + 266);

    // Ten colour toggles during WAIT; the log keeps the last eight.
    b1.stopped = 1'b0;
    b1.colour  = 1'b0;
    repeat (4) @(negedge clk);
    go1(g);
    q1.push_back('{g + 33, 1'b0, 1'b0, 31, 32'hAA, 8});
    for (int i = 0; i < 10; i++) begin
      wait_until(g + 10 + 2 * i);
      b1.colour = ~b1.colour;
    end
    wait_until(g + 30);
    b1.stopped = 1'b1;
    wait_until(g + 36);

    // go held high: back-to-back runs with one IDLE cycle between them.
    b1.colour  = 1'b1;
    b1.stopped = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    b1.go = 1'b1;
    g = cyc + 1;
    q1.push_back('{g + 7,  1'b1, 1'b0, 5, 0, 0});
    q1.push_back('{g + 16, 1'b1, 1'b0, 5, 0, 0});
    q1.push_back('{g + 25, 1'b1, 1'b0, 5, 0, 0});
    @(negedge clk);
    chk("t5_log_cleared", 32'(b1.colour_log), 32'd0);
    chk("t5_count_cleared", 32'(b1.log_count), 32'd0);
    wait_until(g + 8);
    chk("t5_idle1_busy", {31'd0, b1.busy}, 32'd0);
    chk("t5_idle1_start", {31'd0, b1.start}, 32'd0);
    wait_until(g + 9);
    chk("t5_run2_start", {31'd0, b1.start}, 32'd1);
    chk("t5_run2_cycles_cleared", 32'(b1.run_cycles), 32'd0);
    wait_until(g + 17);
    chk("t5_idle2_busy", {31'd0, b1.busy}, 32'd0);
    wait_until(g + 19);
    b1.go = 1'b0;
    wait_until(g + 30);
    chk("t5_no_fourth_run", {31'd0, b1.busy}, 32'd0);

    // Reset during SETTLE, then during START, then a normal run.
    b1.stopped = 1'b0;
    repeat (4) @(negedge clk);
    go1(g);
    wait_until(g + 3);
    chk("t6_settle_busy", {31'd0, b1.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared("t6_rst_settle");
    rst = 1'b0;
    go1(g);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared("t6_rst_start");
    rst = 1'b0;
    b1.stopped = 1'b1;
    repeat (4) @(negedge clk);
    go1(g);
    q1.push_back('{g + 7, 1'b1, 1'b0, 5, 0, 0});
    wait_until(g + 12);

    // Narrow counter: 24 live cycles saturate a 4-bit run_cycles at 15.
    go2(g);
    q2.push_back('{g + 26, 1'b0, 1'b1, 15, 0, 0});
    wait_until(g + 30);

    repeat (3) @(negedge clk);
    chk("dut1_results_pending", q1.size(), 32'd0);
    chk("dut2_results_pending", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
